// File: rtl/dct_stream_dma.sv
// Memory-to-core streaming engine: SRAM -> DCT core input, DCT core output -> SRAM.
// Latency: first word on m_data two cycles after start; writes are combinational from the s-handshake.
// Backpressure: reads are credit-limited by buffer space, m_ready stalls the buffer head, s_ready drops once the run is written.
module dct_stream_dma #(
   parameter int ADDR_W    = 15,
   parameter int IN_W      = 64,
   parameter int OUT_W     = 96,
   parameter int BUF_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] rd_base,
   input  logic [ADDR_W-1:0] wr_base,
   input  logic [ADDR_W:0]   num_words,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [IN_W-1:0]   rd_data,
   output logic [IN_W-1:0]   m_data,
   output logic              m_valid,
   input  logic              m_ready,
   input  logic [OUT_W-1:0]  s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [OUT_W-1:0]  wr_data,
   output logic              busy,
   output logic              done,
   output logic [31:0]       cycle_count
);

   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] rd_base_q;
   logic [ADDR_W-1:0] wr_base_q;
   logic [ADDR_W:0]   len;
   logic [ADDR_W:0]   rd_cnt;
   logic [ADDR_W:0]   wr_cnt;
   logic [31:0]       cyc;
   logic              rd_pend;

   logic [IN_W-1:0]   buf_mem [BUF_DEPTH];
   logic [PW-1:0]     wptr;
   logic [PW-1:0]     rptr;
   logic [CW-1:0]     occ;

   logic              active;
   logic              start_ok;
   logic [ADDR_W:0]   len_clamped;
   logic              push;
   logic              pop;
   logic              last_rd;
   logic              last_wr;
   logic              flush;

   // Control decode shared by the FSM and datapath
   always_comb begin
      active      = (state == RUN) || (state == DRAIN);
      start_ok    = start && ((state == IDLE) || (state == DONE));
      // Only 2^ADDR_W itself has the top bit set among legal lengths, so any
      // value with the top bit set collapses to exactly 2^ADDR_W.
      len_clamped = num_words[ADDR_W] ? {1'b1, {ADDR_W{1'b0}}} : num_words;
      push        = rd_pend && active;
      pop         = m_valid && m_ready;
      last_rd     = rd_en && ((rd_cnt + 1'b1) == len);
      last_wr     = wr_en && ((wr_cnt + 1'b1) == len);
      flush       = (state_nxt != RUN) && (state_nxt != DRAIN);
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; the final write wins over the final read in the same cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start_ok) state_nxt = (len_clamped == '0) ? DONE : RUN;
         RUN: begin
            if (last_wr)      state_nxt = DONE;
            else if (last_rd) state_nxt = DRAIN;
         end
         DRAIN: if (last_wr) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: read credit, handshakes and write-through strobe
   always_comb begin
      busy        = active;
      done        = (state == DONE);
      rd_en       = (state == RUN) && (rd_cnt < len) &&
                    (({1'b0, occ} + (CW+1)'(rd_pend)) < (CW+1)'(BUF_DEPTH));
      rd_addr     = rd_base_q + rd_cnt[ADDR_W-1:0];
      m_valid     = (occ != '0);
      m_data      = m_valid ? buf_mem[rptr] : '0;
      s_ready     = active && (wr_cnt < len);
      wr_en       = s_valid && s_ready;
      wr_addr     = wr_base_q + wr_cnt[ADDR_W-1:0];
      wr_data     = s_data;
      cycle_count = cyc;
   end

   // Run parameters, progress counters and saturating cycle counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_base_q <= '0;
         wr_base_q <= '0;
         len       <= '0;
         rd_cnt    <= '0;
         wr_cnt    <= '0;
         cyc       <= '0;
      end else if (start_ok) begin
         rd_base_q <= rd_base;
         wr_base_q <= wr_base;
         len       <= len_clamped;
         rd_cnt    <= '0;
         wr_cnt    <= '0;
         cyc       <= '0;
      end else begin
         if (rd_en) rd_cnt <= rd_cnt + 1'b1;
         if (wr_en) wr_cnt <= wr_cnt + 1'b1;
         if (active && (cyc != 32'hFFFF_FFFF)) cyc <= cyc + 1'b1;
      end
   end

   // Marks the cycle in which the SRAM returns data for last cycle's read
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rd_pend <= 1'b0;
      else       rd_pend <= rd_en;
   end

   // Buffer pointers and occupancy; emptied whenever the run is not continuing
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
         occ  <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
         occ  <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // Buffer storage; contents are only observed through the occupancy-gated head
   always_ff @(posedge clk) begin
      if (push) buf_mem[wptr] <= rd_data;
   end

endmodule

// File: tb/tb_dct_stream_dma.sv
// Self-checking bench for dct_stream_dma with SRAM models and a pass-through core.
// Latency: expected writes are queued at start and matched against each wr_en.
// Backpressure: core readiness is held high, randomised at 20% duty, or held low.
module tb_dct_stream_dma;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [14:0] rd_base;
   logic [14:0] wr_base;
   logic [15:0] num_words;
   logic        rd_en;
   logic [14:0] rd_addr;
   logic [63:0] rd_data;
   logic [63:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic [95:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic        wr_en;
   logic [14:0] wr_addr;
   logic [95:0] wr_data;
   logic        busy;
   logic        done;
   logic [31:0] cycle_count;

   int          checks = 0;
   int          errors = 0;
   int          wr_seen = 0;
   int          stall_mode = 0;
   logic        stall_n = 1'b1;

   logic [14:0]  rd_q [$];
   logic [110:0] wr_q [$];

   logic        prev_hold = 1'b0;
   logic [63:0] prev_data = '0;

   always #5 clk = ~clk;

   dct_stream_dma dut (
      .clk(clk), .reset(reset), .start(start),
      .rd_base(rd_base), .wr_base(wr_base), .num_words(num_words),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .cycle_count(cycle_count)
   );

   // Pass-through core with zero extension; both sides stall together
   assign s_valid = m_valid & stall_n;
   assign m_ready = s_ready & stall_n;
   assign s_data  = {32'h0, m_data};

   function automatic logic [63:0] pix(input logic [14:0] a);
      logic [31:0] h;
      h = 32'(a) * 32'h9E37_79B9;
      return {16'hC0DE, 1'b0, a, h};
   endfunction

   // Input SRAM: one-cycle read latency
   always @(posedge clk) begin
      if (rd_en) rd_data <= pix(rd_addr);
   end

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Core readiness pattern, changed just after each rising edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (stall_mode)
            0:       stall_n = 1'b1;
            1:       stall_n = ($urandom_range(0, 4) == 0);
            default: stall_n = 1'b0;
         endcase
      end
   end

   // Monitor: read addresses, written words and stall stability
   always @(negedge clk) begin
      if (rd_en) begin
         if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
         else check("rd_addr", rd_addr, rd_q.pop_front());
      end
      if (wr_en) begin
         wr_seen++;
         if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
         else check("wr_word", {wr_addr, wr_data}, wr_q.pop_front());
      end
      if (prev_hold && m_valid) check("m_hold", m_data, prev_data);
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
   end

   task automatic check_reset_outputs();
      check("rst_rd_en", rd_en, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_s_ready", s_ready, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_m_data", m_data, 0);
      check("rst_cycle_count", cycle_count, 0);
   endtask

   // One run: queue expectations, pulse start, wait for done with a bound
   task automatic run(input logic [14:0] rb, input logic [14:0] wb, input logic [15:0] n,
                      input bit chk_cyc, input bit inject);
      int n_eff;
      int bound;
      logic [14:0] a;
      n_eff = n[15] ? 32768 : int'(n);
      for (int i = 0; i < n_eff; i++) begin
         a = rb + 15'(i);
         rd_q.push_back(a);
         wr_q.push_back({wb + 15'(i), 32'h0, pix(a)});
      end
      wr_seen = 0;
      @(posedge clk);
      #1;
      rd_base = rb; wr_base = wb; num_words = n; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      if (n_eff == 0) begin
         check("zero_done", done, 1);
         check("zero_busy", busy, 0);
         check("zero_cycles", cycle_count, 0);
      end else begin
         check("start_busy", busy, 1);
         check("start_cyc_clear", cycle_count, 0);
      end
      bound = n_eff * 20 + 100;
      for (int k = 0; k < bound && !done; k++) begin
         if (inject && k == 10) begin
            @(posedge clk);
            #1;
            rd_base = 15'h1234; wr_base = 15'h0777; num_words = 16'd3; start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
         end
         @(negedge clk);
      end
      check("run_done", done, 1);
      check("run_busy", busy, 0);
      check("run_writes", wr_seen, n_eff);
      check("run_rdq_empty", rd_q.size(), 0);
      check("run_wrq_empty", wr_q.size(), 0);
      if (chk_cyc && n_eff > 0) check("run_cycles", cycle_count, n_eff + 2);
      repeat (3) @(negedge clk);
      check("done_hold", done, 1);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; rd_base = '0; wr_base = '0; num_words = '0;
      #12;
      check_reset_outputs();
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Full image; oversize length clamps to 32768 words
      run(15'h0000, 15'h0000, 16'hC000, 1'b1, 1'b0);
      // Read and write address wrap
      run(15'h7FFE, 15'h0010, 16'd4, 1'b1, 1'b0);
      // Random core stalls, write address wraps as well
      stall_mode = 1;
      run(15'h0100, 15'h7FF0, 16'd200, 1'b0, 1'b0);
      stall_mode = 0;
      // Zero length
      run(15'h0055, 15'h0066, 16'd0, 1'b0, 1'b0);
      // Start during RUN is ignored, then a fresh start from DONE
      run(15'h0020, 15'h0040, 16'd50, 1'b1, 1'b1);
      run(15'h0300, 15'h0500, 16'd8, 1'b1, 1'b0);

      // Reset in DRAIN: core held off so all reads land in the buffer
      stall_mode = 2;
      for (int i = 0; i < 4; i++) begin
         rd_q.push_back(15'h0400 + 15'(i));
         wr_q.push_back({15'h0600 + 15'(i), 32'h0, pix(15'h0400 + 15'(i))});
      end
      @(posedge clk);
      #1;
      rd_base = 15'h0400; wr_base = 15'h0600; num_words = 16'd4; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(negedge clk);
      check("drain_busy", busy, 1);
      check("drain_reads", rd_q.size(), 0);
      check("drain_m_valid", m_valid, 1);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check_reset_outputs();
      wr_q.delete();
      rd_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      stall_mode = 0;
      run(15'h0700, 15'h0800, 16'd6, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
